// File: rtl/rvseed_axi_rd_arb_pkg.sv
// Shared AXI widths, arbiter FSM encoding and helpers
// for the RVSEED AXI read-port arbiter.
package rvseed_axi_rd_arb_pkg;

  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rvseed_axi_rd_arb_rr.sv
// Round-robin picker: first set request at or after
// ptr, wrapping in index order. Pure combinational.
module rvseed_rr_arb
  import rvseed_axi_rd_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // scan NREQ slots starting at ptr, keep the first hit
  always_comb begin : pick
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rvseed_axi_rd_arb.sv
// Shares one AXI4 read master between NREQ requesters,
// one outstanding burst, R beats steered to the owner.
module rvseed_axi_rd_arb
  import rvseed_axi_rd_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ID_W   = AXI_ID_WIDTH,
  parameter int ADDR_W = AXI_ADDR_WIDTH,
  parameter int DATA_W = AXI_DATA_WIDTH,
  parameter int LEN_W  = AXI_LEN_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NREQ-1:0]          s_arvalid,
  output logic [NREQ-1:0]          s_arready,
  input  logic [NREQ*ID_W-1:0]     s_arid,
  input  logic [NREQ*ADDR_W-1:0]   s_araddr,
  input  logic [NREQ*LEN_W-1:0]    s_arlen,
  input  logic [NREQ*3-1:0]        s_arsize,
  input  logic [NREQ*2-1:0]        s_arburst,
  output logic [NREQ-1:0]          s_rvalid,
  input  logic [NREQ-1:0]          s_rready,
  output logic [ID_W-1:0]          s_rid,
  output logic [DATA_W-1:0]        s_rdata,
  output logic [1:0]               s_rresp,
  output logic                     s_rlast,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [ID_W-1:0]          m_arid,
  output logic [ADDR_W-1:0]        m_araddr,
  output logic [LEN_W-1:0]         m_arlen,
  output logic [2:0]               m_arsize,
  output logic [1:0]               m_arburst,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  input  logic [ID_W-1:0]          m_rid,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  output logic                     arb_busy,
  output logic [idx_w(NREQ)-1:0]   arb_owner
);

  localparam int IW = idx_w(NREQ);

  arb_state_e      state;
  arb_state_e      state_nx;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [NREQ-1:0] g_oh;
  logic [IW-1:0]   g_idx;
  logic            g_any;
  logic            grant;
  logic            ar_hs;
  logic            last_beat;

  rvseed_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req (s_arvalid),
    .ptr (rr_ptr),
    .gnt (g_oh),
    .idx (g_idx),
    .any (g_any)
  );

  // reset gates the grant so s_arready is low while held
  assign grant = rst_n & enable & g_any
               & (state == ARB_IDLE);
  assign ar_hs = m_arvalid & m_arready;
  assign last_beat = (state == ARB_R) & m_rvalid
                   & m_rready & m_rlast;

  assign arb_busy  = (state != ARB_IDLE);
  assign arb_owner = owner;

  assign s_rid   = m_rid;
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

  // next state plus grant/steering outputs
  always_comb begin
    state_nx  = state;
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (grant) begin
          s_arready = g_oh;
          state_nx  = ARB_AR;
        end
      end
      ARB_AR: begin
        if (ar_hs) state_nx = ARB_R;
      end
      ARB_R: begin
        m_rready        = s_rready[owner];
        s_rvalid[owner] = m_rvalid;
        if (last_beat) state_nx = ARB_IDLE;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nx;
  end

  // AR payload capture and master AR valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
    end else if (grant) begin
      m_arvalid <= 1'b1;
      m_arid    <= s_arid[int'(g_idx)*ID_W +: ID_W];
      m_araddr  <= s_araddr[int'(g_idx)*ADDR_W +: ADDR_W];
      m_arlen   <= s_arlen[int'(g_idx)*LEN_W +: LEN_W];
      m_arsize  <= s_arsize[int'(g_idx)*3 +: 3];
      m_arburst <= s_arburst[int'(g_idx)*2 +: 2];
    end else if (ar_hs) begin
      m_arvalid <= 1'b0;
    end
  end

  // owner on grant, pointer moves past owner at burst end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      if (grant) owner <= g_idx;
      if (last_beat) begin
        if (owner == IW'(NREQ - 1)) rr_ptr <= '0;
        else                        rr_ptr <= owner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rvseed_axi_rd_arb.sv
// Scoreboard bench for rvseed_axi_rd_arb: slave model,
// per-port expected R queues, directed grant checks.
module tb_rvseed_axi_rd_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  s_arvalid, s_arready;
  logic [7:0]  s_arid;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [5:0]  s_arsize;
  logic [3:0]  s_arburst;
  logic [1:0]  s_rvalid, s_rready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        m_arvalid, m_arready;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        arb_busy;
  logic [0:0]  arb_owner;

  rvseed_axi_rd_arb dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .arb_busy(arb_busy), .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp0[$];
  logic [36:0] exp1[$];
  int gq[$];
  int beats[2];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rmodel(
    input logic [31:0] a, input int b);
    return 32'h0010_0093 + (a - 32'h100) + 32'(b << 4);
  endfunction

  task automatic push(input int i, input logic [36:0] v);
    if (i == 0) exp0.push_back(v);
    else        exp1.push_back(v);
  endtask

  task automatic issue(input int i,
                       input logic [31:0] addr,
                       input logic [7:0] len);
    int t;
    for (int b = 0; b <= int'(len); b++)
      push(i, {b == int'(len), 4'(i + 1), rmodel(addr, b)});
    s_araddr[i*32 +: 32] = addr;
    s_arlen[i*8 +: 8]    = len;
    s_arid[i*4 +: 4]     = 4'(i + 1);
    s_arsize[i*3 +: 3]   = 3'd2;
    s_arburst[i*2 +: 2]  = 2'b01;
    s_arvalid[i] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_arready[i] && t < 300);
    if (!s_arready[i]) chk("ar_grant_to", s_arready[i], 1);
    @(posedge clk); #1;
    s_arvalid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (arb_busy && t < 300);
    if (arb_busy) chk("idle_to", arb_busy, 0);
    @(posedge clk); #1;
  endtask

  // requester-side monitor: grants and R beats
  always @(negedge clk) begin
    logic [36:0] obs, e;
    for (int i = 0; i < 2; i++) begin
      if (s_arready[i]) gq.push_back(i);
      if (s_rvalid[i] && s_rready[i]) begin
        beats[i]++;
        obs = {s_rlast, s_rid, s_rdata};
        if (i == 0) begin
          if (exp0.size() == 0) chk("r0_stray", exp0.size(), 1);
          else begin
            e = exp0.pop_front();
            chk("r0_beat", obs, e);
          end
        end else begin
          if (exp1.size() == 0) chk("r1_stray", exp1.size(), 1);
          else begin
            e = exp1.pop_front();
            chk("r1_beat", obs, e);
          end
        end
      end
    end
  end

  // AXI slave model: one burst at a time, aborts on reset
  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [3:0]  id;
    int t;
    bit ab;
    m_rvalid = 1'b0;
    m_rid = '0;
    m_rdata = '0;
    m_rresp = '0;
    m_rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && m_arvalid && m_arready) begin
        a = m_araddr;
        l = m_arlen;
        id = m_arid;
        @(posedge clk); #1;
        ab = 1'b0;
        for (int b = 0; b <= int'(l) && !ab; b++) begin
          m_rvalid = 1'b1;
          m_rdata  = rmodel(a, b);
          m_rid    = id;
          m_rresp  = 2'b00;
          m_rlast  = (b == int'(l));
          t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (rst_n && !m_rready && t < 300);
          if (!rst_n) ab = 1'b1;
          else begin
            if (!m_rready) chk("rbeat_to", m_rready, 1);
            @(posedge clk); #1;
          end
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, b0, t;
    rst_n = 1'b0;
    enable = 1'b1;
    s_arvalid = '0;
    s_arid = '0;
    s_araddr = '0;
    s_arlen = '0;
    s_arsize = '0;
    s_arburst = '0;
    s_rready = 2'b11;
    m_arready = 1'b1;
    beats[0] = 0;
    beats[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_owner", arb_owner, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_srvalid", s_rvalid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // contention from reset: 0,1,0,1
    base = gq.size();
    fork
      begin
        issue(0, 32'h1000, 0);
        issue(0, 32'h1100, 1);
      end
      begin
        issue(1, 32'h1200, 0);
        issue(1, 32'h1300, 0);
      end
    join
    wait_idle();
    chk("rr_g0", gq[base + 0], 0);
    chk("rr_g1", gq[base + 1], 1);
    chk("rr_g2", gq[base + 2], 0);
    chk("rr_g3", gq[base + 3], 1);
    chk("rr_owner", arb_owner, 1);

    // single IFU fetch
    b0 = beats[0];
    push(0, {1'b1, 4'd1, 32'h0010_0093});
    s_araddr[31:0] = 32'h100;
    s_arlen[7:0] = 8'd0;
    s_arid[3:0] = 4'd1;
    s_arvalid[0] = 1'b1;
    @(negedge clk);
    chk("t1_arready", s_arready, 2'b01);
    @(posedge clk); #1;
    s_arvalid[0] = 1'b0;
    @(negedge clk);
    chk("t1_marvalid", m_arvalid, 1);
    chk("t1_maraddr", m_araddr, 32'h100);
    chk("t1_busy", arb_busy, 1);
    t = 0;
    while (s_rvalid == 2'b00 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t1_srvalid", s_rvalid, 2'b01);
    chk("t1_rdata", s_rdata, 32'h0010_0093);
    wait_idle();
    chk("t1_beats", beats[0] - b0, 1);

    // 4-beat burst to port 1 with requester stall
    b0 = beats[1];
    fork
      issue(1, 32'h2000, 8'd3);
      begin
        t = 0;
        while (beats[1] < b0 + 2 && t < 100) begin
          @(posedge clk);
          t++;
        end
        #1;
        s_rready[1] = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("t3_mrready", m_rready, 0);
          chk("t3_srvalid", s_rvalid, 2'b10);
        end
        @(posedge clk); #1;
        s_rready[1] = 1'b1;
      end
    join
    wait_idle();
    chk("t3_beats", beats[1] - b0, 4);
    chk("t3_q1", exp1.size(), 0);

    // AR backpressure, port 1 pending meanwhile
    m_arready = 1'b0;
    base = gq.size();
    fork
      issue(0, 32'h3000, 8'd0);
      issue(1, 32'h4000, 8'd1);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!m_arvalid && t < 50);
        for (int k = 0; k < 5; k++) begin
          chk("t4_arvalid", m_arvalid, 1);
          chk("t4_araddr", m_araddr, 32'h3000);
          chk("t4_arready", s_arready, 0);
          if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        m_arready = 1'b1;
      end
    join
    wait_idle();
    chk("t4_g0", gq[base + 0], 0);
    chk("t4_g1", gq[base + 1], 1);

    // enable dropped during R of port 0
    base = gq.size();
    b0 = beats[0];
    fork
      issue(0, 32'h5000, 8'd3);
      issue(1, 32'h6000, 8'd0);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!s_rvalid[0] && t < 50);
        @(posedge clk); #1;
        enable = 1'b0;
        wait_idle();
        chk("t5_beats0", beats[0] - b0, 4);
        repeat (4) begin
          @(negedge clk);
          chk("t5_noarready", s_arready, 0);
          chk("t5_idle", arb_busy, 0);
        end
        chk("t5_ngrant", gq.size() - base, 1);
        @(posedge clk); #1;
        enable = 1'b1;
      end
    join
    wait_idle();
    chk("t5_g1", gq[base + 1], 1);

    // reset mid-burst, pointer returns to 0
    issue(0, 32'h7000, 8'd0);
    wait_idle();
    issue(1, 32'h8000, 8'd7);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_rvalid[1] && t < 50);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", arb_busy, 0);
    chk("t6_mrready", m_rready, 0);
    chk("t6_srvalid", s_rvalid, 0);
    chk("t6_owner", arb_owner, 0);
    chk("t6_araddr", m_araddr, 0);
    exp1.delete();
    @(posedge clk); #1;
    base = gq.size();
    fork
      issue(0, 32'h9000, 8'd0);
      issue(1, 32'hA000, 8'd0);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("t6_rst_arready", s_arready, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    join
    wait_idle();
    chk("t6_first", gq[base], 0);
    chk("end_q0", exp0.size(), 0);
    chk("end_q1", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
